// File: rtl/bist_pkg.sv
// Shared constants and state types for the ALU runtime-BIST APB sequencer.
// Register map of the BIST controller plus FSM encodings.
package bist_pkg;

  localparam logic [31:0] CTRL_ADDR   = 32'h0;
  localparam logic [31:0] STATUS_ADDR = 32'h4;

  localparam int CTRL_EN     = 0;
  localparam int STATUS_DONE = 0;
  localparam int STATUS_FAIL = 1;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    BIST_FAIL = 2'b01,
    POLL_TO   = 2'b10,
    APB_TO    = 2'b11
  } seq_err_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS
  } apb_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN,
    S_GAP,
    S_POLL,
    S_DIS,
    S_FIN
  } seq_state_e;

endpackage

// File: rtl/bist_apb_sequencer_apb_master_fsm.sv
// Single-transfer APB master: request/response on one side, APB on the other.
// Owns the ACCESS-phase timeout counter.
module apb_master_fsm
  import bist_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int APB_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int CW = $clog2(APB_TIMEOUT + 1);

  apb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire, done, abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      A_IDLE: begin
        if (req_valid_i) begin
          fire    = 1'b1;
          state_d = A_SETUP;
        end
      end
      A_SETUP: begin
        state_d = A_ACCESS;
        cnt_d   = '0;
      end
      A_ACCESS: begin
        if (pready_i) begin
          done    = 1'b1;
          state_d = A_IDLE;
        end else if (cnt_q == CW'(APB_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = A_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= A_IDLE;
      cnt_q       <= '0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_o <= done | abort;
      rsp_err_o   <= abort;
      if (fire) begin
        paddr_o  <= req_addr_i;
        pwrite_o <= req_write_i;
        pwdata_o <= req_wdata_i;
      end
      if (done)
        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
      else if (abort)
        rsp_rdata_o <= '0;
    end
  end

  assign req_ready_o = (state_q == A_IDLE);
  assign psel_o      = (state_q != A_IDLE);
  assign penable_o   = (state_q == A_ACCESS);

endmodule

// File: rtl/bist_apb_sequencer.sv
// Self-test sequencer and debug command port sharing one APB master
// that drives the ALU runtime-BIST controller.
module bist_apb_sequencer
  import bist_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int APB_TIMEOUT = 16,
  parameter int POLL_GAP    = 8,
  parameter int MAX_POLLS   = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              seq_busy_o,
  output logic              seq_done_o,
  output logic              seq_pass_o,
  output logic [1:0]        seq_err_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 2);

  seq_state_e    st_q, st_d;
  seq_err_e      err_q, err_d;
  logic          pass_q, pass_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          issued_q, issued_d;
  logic          cmd_pend_q;

  logic              seq_req, seq_write, seq_own, seq_rsp;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_wdata;
  logic              start_ok, cmd_fire;

  logic              m_req_valid, m_req_ready, m_req_write;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic              m_rsp_valid, m_rsp_err;
  logic [DATA_W-1:0] m_rsp_rdata;

  assign seq_own  = st_q inside {S_EN, S_GAP, S_POLL, S_DIS};
  assign start_ok = start_i && (st_q == S_IDLE) && !cmd_pend_q
                    && m_req_ready;
  assign seq_rsp  = m_rsp_valid && !cmd_pend_q;

  // Gated by rst_ni so the port reads 0 while reset is held.
  assign cmd_ready_o = rst_ni && m_req_ready && !seq_own
                       && !start_i && !cmd_pend_q;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  assign m_req_valid = seq_own ? seq_req   : cmd_fire;
  assign m_req_write = seq_own ? seq_write : cmd_write_i;
  assign m_req_addr  = seq_own ? seq_addr  : cmd_addr_i;
  assign m_req_wdata = seq_own ? seq_wdata : cmd_wdata_i;

  assign rsp_valid_o = m_rsp_valid && cmd_pend_q;
  assign rsp_err_o   = rsp_valid_o && m_rsp_err;
  assign rsp_rdata_o = rsp_valid_o ? m_rsp_rdata : '0;

  assign seq_busy_o = seq_own;
  assign seq_done_o = (st_q == S_FIN);
  assign seq_pass_o = pass_q;
  assign seq_err_o  = err_q;

  always_comb begin
    st_d      = st_q;
    err_d     = err_q;
    pass_d    = pass_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    issued_d  = issued_q;
    seq_req   = 1'b0;
    seq_write = 1'b0;
    seq_addr  = ADDR_W'(CTRL_ADDR);
    seq_wdata = '0;
    unique case (st_q)
      S_IDLE: begin
        if (start_ok) begin
          st_d     = S_EN;
          err_d    = NONE;
          pass_d   = 1'b0;
          poll_d   = '0;
          issued_d = 1'b0;
        end
      end
      S_EN: begin
        seq_req            = !issued_q;
        seq_write          = 1'b1;
        seq_wdata[CTRL_EN] = 1'b1;
        if (seq_req && m_req_ready) issued_d = 1'b1;
        if (seq_rsp) begin
          issued_d = 1'b0;
          gap_d    = '0;
          if (m_rsp_err) begin
            err_d = APB_TO;
            st_d  = S_FIN;
          end else begin
            st_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q + GW'(1) >= GW'(POLL_GAP)) st_d = S_POLL;
        else gap_d = gap_q + GW'(1);
      end
      S_POLL: begin
        seq_req  = !issued_q;
        seq_addr = ADDR_W'(STATUS_ADDR);
        if (seq_req && m_req_ready) issued_d = 1'b1;
        if (seq_rsp) begin
          issued_d = 1'b0;
          gap_d    = '0;
          if (m_rsp_err) begin
            err_d = APB_TO;
            st_d  = S_FIN;
          end else if (m_rsp_rdata[STATUS_DONE]) begin
            err_d = m_rsp_rdata[STATUS_FAIL] ? BIST_FAIL : NONE;
            st_d  = S_DIS;
          end else if (poll_q == PW'(MAX_POLLS - 1)) begin
            err_d = POLL_TO;
            st_d  = S_DIS;
          end else begin
            poll_d = poll_q + PW'(1);
            st_d   = S_GAP;
          end
        end
      end
      S_DIS: begin
        seq_req   = !issued_q;
        seq_write = 1'b1;
        if (seq_req && m_req_ready) issued_d = 1'b1;
        if (seq_rsp) begin
          issued_d = 1'b0;
          if (m_rsp_err) err_d = APB_TO;
          st_d = S_FIN;
        end
      end
      S_FIN: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (st_d == S_FIN && st_q != S_FIN) pass_d = (err_d == NONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q       <= S_IDLE;
      err_q      <= NONE;
      pass_q     <= 1'b0;
      poll_q     <= '0;
      gap_q      <= '0;
      issued_q   <= 1'b0;
      cmd_pend_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      issued_q <= issued_d;
      if (cmd_fire) cmd_pend_q <= 1'b1;
      else if (m_rsp_valid) cmd_pend_q <= 1'b0;
    end
  end

  apb_master_fsm #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .APB_TIMEOUT (APB_TIMEOUT)
  ) u_apb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (m_req_valid),
    .req_ready_o (m_req_ready),
    .req_write_i (m_req_write),
    .req_addr_i  (m_req_addr),
    .req_wdata_i (m_req_wdata),
    .rsp_valid_o (m_rsp_valid),
    .rsp_err_o   (m_rsp_err),
    .rsp_rdata_o (m_rsp_rdata),
    .paddr_o     (paddr_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i)
  );

endmodule

// File: tb/tb_bist_apb_sequencer.sv
// Scoreboard bench for bist_apb_sequencer: APB slave model with wait states,
// expected bus traffic, command responses and sequence results.
module tb_bist_apb_sequencer;

  localparam int TO = 16;
  localparam int GAP = 2;
  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        seq_busy_o, seq_done_o, seq_pass_o;
  logic [1:0]  seq_err_o;
  logic [31:0] paddr_o, pwdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  always #5 clk = ~clk;

  bist_apb_sequencer #(
    .ADDR_W(32), .DATA_W(32), .APB_TIMEOUT(TO),
    .POLL_GAP(GAP), .MAX_POLLS(MP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o),
    .seq_pass_o(seq_pass_o), .seq_err_o(seq_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata), .pready_i(pready)
  );

  typedef struct { bit w; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { logic [31:0] rdata; bit err; } rsp_t;
  typedef struct { logic [1:0] err; bit pass; } seq_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  seq_t exp_seq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // APB slave: memory, STATUS value queue, wait states, hang mode
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] status_q[$];
  logic [31:0] status_dflt = '0;
  bit          hang = 1'b0;
  int          wait_st = 0;
  int          wcnt = 0;

  task automatic bus_seen(input bit w, input logic [31:0] a,
                          input logic [31:0] d);
    bus_t e;
    if (exp_bus.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL bus_extra: got w=%0b addr=%0h data=%0h, required none",
               w, a, d);
    end else begin
      e = exp_bus.pop_front();
      chk("bus_w", 64'(w), 64'(e.w));
      chk("bus_addr", 64'(a), 64'(e.addr));
      if (e.w) chk("bus_wdata", 64'(d), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n || !(psel_o && penable_o) || hang) begin
      pready = 1'b0;
      wcnt = 0;
    end else if (!pready) begin
      if (wcnt >= wait_st) begin
        pready = 1'b1;
        if (pwrite_o) begin
          mem[paddr_o[5:2]] = pwdata_o;
          bus_seen(1'b1, paddr_o, pwdata_o);
        end else begin
          if (paddr_o == 32'h4 && status_q.size() > 0)
            prdata = status_q.pop_front();
          else if (paddr_o == 32'h4)
            prdata = status_dflt;
          else
            prdata = mem[paddr_o[5:2]];
          bus_seen(1'b0, paddr_o, prdata);
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Response / result monitor
  always @(negedge clk) begin : mon
    rsp_t er;
    seq_t es;
    if (rst_n) begin
      if (rsp_valid_o) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_extra: got rdata=%0h err=%0b, required none",
                   rsp_rdata_o, rsp_err_o);
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata_o), 64'(er.rdata));
          chk("rsp_err", 64'(rsp_err_o), 64'(er.err));
        end
      end
      if (seq_done_o) begin
        if (exp_seq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL seq_done_extra: got err=%0b pass=%0b, required none",
                   seq_err_o, seq_pass_o);
        end else begin
          es = exp_seq.pop_front();
          chk("seq_err", 64'(seq_err_o), 64'(es.err));
          chk("seq_pass", 64'(seq_pass_o), 64'(es.pass));
          chk("busy_at_done", 64'(seq_busy_o), 64'(0));
        end
      end
    end
  end

  // Reference: what a self-test run does for a given STATUS stream
  task automatic expect_seq(input logic [31:0] sq[$],
                            input logic [31:0] dflt);
    logic [1:0]  e;
    logic [31:0] v;
    bit          fin;
    e = 2'b10;
    fin = 1'b0;
    exp_bus.push_back('{w: 1'b1, addr: 32'h0, data: 32'h1});
    for (int p = 0; p < MP && !fin; p++) begin
      v = (p < sq.size()) ? sq[p] : dflt;
      exp_bus.push_back('{w: 1'b0, addr: 32'h4, data: 32'h0});
      if (v[0]) begin
        fin = 1'b1;
        e = v[1] ? 2'b01 : 2'b00;
      end
    end
    exp_bus.push_back('{w: 1'b1, addr: 32'h0, data: 32'h0});
    exp_seq.push_back('{err: e, pass: (e == 2'b00)});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_seq.size() != 0 || exp_rsp.size() != 0 ||
                exp_bus.size() != 0 || seq_busy_o || psel_o) && n < 3000);
    chk({name, "_complete"}, 64'(n < 3000), 64'(1));
  endtask

  task automatic run_seq(input logic [31:0] sq[$], input logic [31:0] dflt);
    status_q = sq;
    status_dflt = dflt;
    expect_seq(sq, dflt);
    pulse_start();
    wait_idle("seq_run");
  endtask

  task automatic do_cmd(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input rsp_t r,
                        input bit on_bus);
    int n;
    exp_rsp.push_back(r);
    if (on_bus) exp_bus.push_back('{w: w, addr: a, data: d});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(n < 100), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"},
        64'({cmd_ready_o, rsp_valid_o, rsp_err_o, seq_busy_o, seq_done_o,
             seq_pass_o, seq_err_o, psel_o, penable_o, pwrite_o}), 64'(0));
    chk({name, "_paddr"}, 64'(paddr_o), 64'(0));
    chk({name, "_pwdata"}, 64'(pwdata_o), 64'(0));
    chk({name, "_rdata"}, 64'(rsp_rdata_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sq[$];
    logic [31:0] d, v;
    int n, acc, ps, k, idx;
    bit w;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // pass after two not-done polls, zero-wait slave
    wait_st = 0;
    sq = '{32'h0, 32'h0, 32'h1};
    run_seq(sq, 32'h0);

    // BIST reports fail on first poll
    sq = '{32'h3};
    run_seq(sq, 32'h0);

    // never done: poll timeout after MP reads
    sq = {};
    run_seq(sq, 32'h0);

    // APB timeout on the enable write
    hang = 1'b1;
    exp_seq.push_back('{err: 2'b11, pass: 1'b0});
    pulse_start();
    n = 0;
    while (!penable_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = 0;
    while (penable_o && acc < 100) begin
      acc++;
      @(negedge clk);
    end
    chk("apb_timeout_cycles", 64'(acc), 64'(TO));
    chk("apb_timeout_psel", 64'(psel_o), 64'(0));
    wait_idle("apb_to");
    hang = 1'b0;
    ps = 0;
    repeat (20) begin
      @(negedge clk);
      if (psel_o) ps++;
    end
    chk("no_disable_after_to", 64'(ps), 64'(0));

    // command read with 3 wait states; start during it is ignored
    wait_st = 3;
    status_q = '{32'hA5A5_0001};
    do_cmd(1'b0, 32'h4, 32'h0, '{rdata: 32'hA5A5_0001, err: 1'b0}, 1'b1);
    pulse_start();
    chk("start_ignored_busy", 64'(seq_busy_o), 64'(0));
    wait_idle("cmd_read");

    // command timeout
    hang = 1'b1;
    do_cmd(1'b0, 32'h10, 32'h0, '{rdata: 32'h0, err: 1'b1}, 1'b0);
    wait_idle("cmd_to");
    hang = 1'b0;

    // start and cmd_valid together: sequencer wins
    wait_st = 1;
    sq = '{32'h1};
    status_q = sq;
    expect_seq(sq, 32'h0);
    @(negedge clk);
    start = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h8;
    cmd_wdata = 32'hDEAD_BEEF;
    #1;
    chk("cmd_ready_vs_start", 64'(cmd_ready_o), 64'(0));
    @(negedge clk);
    start = 1'b0;
    cmd_valid = 1'b0;
    wait_idle("start_wins");

    // reset during ACCESS of a hung command write
    hang = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h8;
    cmd_wdata = 32'h1234_5678;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!penable_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid_access");
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_psel", 64'(psel_o), 64'(0));

    // fresh run after reset
    sq = '{32'h0, 32'h1};
    run_seq(sq, 32'h0);

    // randomized mix of sequences and commands
    repeat (24) begin
      wait_st = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        sq = {};
        k = $urandom_range(0, 5);
        repeat (k) begin
          v = $urandom;
          sq.push_back(v & 32'hFFFF_FFFE);
        end
        v = $urandom;
        sq.push_back(v | 32'h1);
        run_seq(sq, 32'h0);
      end else begin
        w = 1'($urandom_range(0, 1));
        idx = $urandom_range(2, 15);
        d = $urandom;
        if (w) begin
          ref_mem[idx] = d;
          do_cmd(1'b1, 32'(idx * 4), d, '{rdata: 32'h0, err: 1'b0}, 1'b1);
        end else begin
          do_cmd(1'b0, 32'(idx * 4), 32'h0,
                 '{rdata: ref_mem[idx], err: 1'b0}, 1'b1);
        end
        wait_idle("cmd_rand");
      end
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
